// File: rtl/uart_digit_shift_ctrl_if.sv
// Bundles the UART byte strobe and the 7-seg shift-register drive.
// Pure signal container, no logic and no latency.
// No backpressure: rx_valid is a one-cycle strobe; overflow reports drops.
interface uart_digit_shift_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] digit_data;
    logic       shift_clk;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    // Source side: drives received bytes, observes the shift-register drive.
    modport master (
        output rx_data, rx_valid,
        input  digit_data, shift_clk, busy, fifo_full, overflow
    );

    // Sequencer side.
    modport slave (
        input  rx_data, rx_valid,
        output digit_data, shift_clk, busy, fifo_full, overflow
    );
endinterface

// File: rtl/uart_digit_shift_ctrl.sv
// Decodes UART ASCII to digit codes, buffers them, and paces shift_clk toggles to the 7-seg shift register.
// Latency: byte sampled at E0, digit_data at E0+1, toggle at E0+1+SETUP_CYCLES, next pop SETUP+SETTLE+1 later.
// No backpressure: a byte that finds no FIFO room is dropped and sets sticky overflow. Option macro: DIGIT_SHIFT_HEX_EN.
module uart_digit_shift_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_digit_shift_ctrl_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, HOLD} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [3:0]     digit_q, digit_d;
    logic           shift_q, shift_d;
    logic           busy_q, busy_d;
    logic           full_q, full_d;
    logic           ovf_q, ovf_d;

    logic [3:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           is_digit, is_clear;
    logic [3:0]     code;
    logic           pop;
    logic [CW-1:0]  free;
    logic           push_one, push_two, drop;

    // Classify the received byte: single digit, clear (two zero entries), or ignored.
    always_comb begin
        is_digit = 1'b0;
        is_clear = 1'b0;
        code     = 4'd0;
        if (bus.rx_valid) begin
            if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
                is_digit = 1'b1;
                code     = bus.rx_data[3:0];
            end
`ifdef DIGIT_SHIFT_HEX_EN
            else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                     (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
                is_digit = 1'b1;
                code     = bus.rx_data[3:0] + 4'd9;
            end else if (bus.rx_data == 8'h1B) begin
                is_clear = 1'b1;
            end
`else
            else if (bus.rx_data == 8'h58 || bus.rx_data == 8'h78) begin
                is_clear = 1'b1;
            end
`endif
        end
    end

    // FIFO admission: a same-cycle pop frees a slot for this cycle's push.
    always_comb begin
        free     = CW'(FIFO_DEPTH) - count_q + CW'(pop);
        push_one = is_digit && (free >= CW'(1));
        push_two = is_clear && (free >= CW'(2));
        drop     = (is_digit && !push_one) || (is_clear && !push_two);
        wr_ptr_d = wr_ptr_q;
        if (push_one) wr_ptr_d = wr_ptr_q + AW'(1);
        if (push_two) wr_ptr_d = wr_ptr_q + AW'(2);
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_one) + (push_two ? CW'(2) : CW'(0)) - CW'(pop);
        ovf_d    = ovf_q | drop;
        busy_d   = (state_d != IDLE) || (count_d != '0);
        full_d   = (count_d == CW'(FIFO_DEPTH));
    end

    // FIFO storage needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push_one) mem_q[wr_ptr_q] <= code;
        if (push_two) begin
            mem_q[wr_ptr_q]          <= 4'd0;
            mem_q[wr_ptr_q + AW'(1)] <= 4'd0;
        end
    end

    // State and control registers; reset abandons any pending toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            digit_q  <= 4'd0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Next-state: pop when data waits, wait out setup, then the downstream settle window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0)        state_d = SETUP;
            SETUP:   if (cnt_q == SETUP_LAST)  state_d = HOLD;
            HOLD:    if (cnt_q == SETTLE_LAST) state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Per-state actions: pop/load digit, run the spacing counter, toggle shift_clk.
    always_comb begin
        pop     = 1'b0;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    digit_d = mem_q[rd_ptr_q];
                    cnt_d   = 8'd0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    shift_d = ~shift_q;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == SETTLE_LAST) cnt_d = 8'd0;
                else                      cnt_d = cnt_q + 8'd1;
            end
            default: ;
        endcase
    end

    assign bus.digit_data = digit_q;
    assign bus.shift_clk  = shift_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_full  = full_q;
    assign bus.overflow   = ovf_q;
endmodule
